lsu: RTL and testbench

Parametrised multi-cycle load/store unit for the core. It sits between the datapath (ALU-computed address, `rs2` store data, register write-back) and a synchronous word-wide data memory. It handles byte, halfword and word accesses with sign or zero extension, byte-enable generation and a request/response handshake. Word accesses that cross a word boundary can optionally be split into two memory accesses.

---
 rtl/lsu.sv | 262 ++++++++++++++++++++++++++
 tb/tb_lsu.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// lsu: multi-cycle load/store unit between the datapath and a synchronous
// word-wide data memory. Handles byte/halfword/word accesses with sign or
// zero extension, byte-enable generation and a request/response handshake.
// Optional feature macro LSU_MISALIGNED_EN: when defined, accesses that cross
// a word boundary are split into two memory accesses; when undefined, any
// access that is not naturally aligned is rejected with resp_err.
module lsu #(
  parameter int WORD_SIZE  = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_store,
  input  logic [1:0]             req_size,
  input  logic                   req_unsigned,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic [WORD_SIZE-1:0]   req_wdata,
  output logic                   resp_valid,
  output logic [WORD_SIZE-1:0]   resp_rdata,
  output logic                   resp_err,
  output logic                   mem_en,
  output logic                   mem_we,
  output logic [WORD_SIZE/8-1:0] mem_be,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [WORD_SIZE-1:0]   mem_wdata,
  input  logic [WORD_SIZE-1:0]   mem_rdata
);
  localparam int NB   = WORD_SIZE / 8;
  localparam int OFFW = $clog2(NB);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, FIN} state_t;
  state_t state, state_n;

  logic                  r_store, r_unsigned;
  logic [1:0]            r_size;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [WORD_SIZE-1:0]  r_wdata;

  logic                  c_store;
  logic [1:0]            c_size;
  logic [ADDR_WIDTH-1:0] c_addr;
  logic [WORD_SIZE-1:0]  c_wdata;

  logic [OFFW-1:0]       off;
  logic [ADDR_WIDTH-1:0] idx0;
  logic [3:0]            base_mask;
  logic [WORD_SIZE-1:0]  trunc;
  logic [WORD_SIZE-1:0]  lo_data;
  logic [NB-1:0]         lo_mask;
  logic                  bad_access;
  logic [WORD_SIZE-1:0]  shifted;
  logic [WORD_SIZE-1:0]  load_value;

  logic                  mem_en_n, mem_we_n;
  logic [NB-1:0]         mem_be_n;
  logic [ADDR_WIDTH-1:0] mem_addr_n;
  logic [WORD_SIZE-1:0]  mem_wdata_n;
  logic                  resp_valid_n, resp_err_n;
  logic [WORD_SIZE-1:0]  resp_rdata_n;

  assign req_ready = (state == IDLE) && resetn;

  // Request fields come straight from the inputs at acceptance and from the registered copy afterwards.
  always_comb begin
    if (state == IDLE) begin
      c_store = req_store;
      c_size  = req_size;
      c_addr  = req_addr;
      c_wdata = req_wdata;
    end else begin
      c_store = r_store;
      c_size  = r_size;
      c_addr  = r_addr;
      c_wdata = r_wdata;
    end
    off  = c_addr[OFFW-1:0];
    idx0 = c_addr >> OFFW;
    case (c_size)
      2'd0: begin
        base_mask = 4'b0001;
        trunc     = WORD_SIZE'(c_wdata[7:0]);
      end
      2'd1: begin
        base_mask = 4'b0011;
        trunc     = WORD_SIZE'(c_wdata[15:0]);
      end
      default: begin
        base_mask = 4'b1111;
        trunc     = WORD_SIZE'(c_wdata[31:0]);
      end
    endcase
  end

`ifdef LSU_MISALIGNED_EN
  logic [OFFW:0]          nbytes;
  logic                   split;
  logic [ADDR_WIDTH-1:0]  idx1;
  logic [2*WORD_SIZE-1:0] wide_data, wide_rdata;
  logic [2*NB-1:0]        wide_mask;
  logic [WORD_SIZE-1:0]   hi_data, word0_buf;
  logic [NB-1:0]          hi_mask;

  // Split detection, two-word store lane placement and two-word load alignment.
  always_comb begin
    case (c_size)
      2'd0:    nbytes = (OFFW+1)'(1);
      2'd1:    nbytes = (OFFW+1)'(2);
      default: nbytes = (OFFW+1)'(4);
    endcase
    split      = ({1'b0, off} + nbytes) > (OFFW+1)'(NB);
    bad_access = (c_size == 2'd3);
    idx1       = idx0 + ADDR_WIDTH'(1);
    wide_data  = (2*WORD_SIZE)'(trunc) << {off, 3'b000};
    wide_mask  = (2*NB)'(base_mask) << off;
    {hi_data, lo_data} = wide_data;
    {hi_mask, lo_mask} = wide_mask;
    wide_rdata = split ? {mem_rdata, word0_buf} : {{WORD_SIZE{1'b0}}, mem_rdata};
    shifted    = WORD_SIZE'(wide_rdata >> {off, 3'b000});
  end

  // Hold word 0 of a split load while word 1 is being fetched.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      word0_buf <= '0;
    end else if (state == ACC1) begin
      word0_buf <= mem_rdata;
    end
  end
`else
  // Aligned-only build: misaligned accesses are rejected and loads use a single word.
  always_comb begin
    bad_access = (c_size == 2'd3) ||
                 (c_size == 2'd1 && off[0]) ||
                 (c_size == 2'd2 && off[1:0] != 2'b00);
    lo_data    = trunc << {off, 3'b000};
    lo_mask    = NB'(base_mask) << off;
    shifted    = mem_rdata >> {off, 3'b000};
  end
`endif

  // Truncate the aligned load data to the access size and extend it to a full word.
  always_comb begin
    case (r_size)
      2'd0:    load_value = r_unsigned ? WORD_SIZE'(shifted[7:0])
                                       : WORD_SIZE'($signed(shifted[7:0]));
      2'd1:    load_value = r_unsigned ? WORD_SIZE'(shifted[15:0])
                                       : WORD_SIZE'($signed(shifted[15:0]));
      default: load_value = r_unsigned ? WORD_SIZE'(shifted[31:0])
                                       : WORD_SIZE'($signed(shifted[31:0]));
    endcase
  end

  // Next state plus the values the registered memory and response outputs take next cycle.
  always_comb begin
    state_n      = state;
    mem_en_n     = 1'b0;
    mem_we_n     = 1'b0;
    mem_be_n     = '0;
    mem_addr_n   = '0;
    mem_wdata_n  = '0;
    resp_valid_n = 1'b0;
    resp_err_n   = resp_err;
    resp_rdata_n = resp_rdata;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (bad_access) begin
            resp_valid_n = 1'b1;
            resp_err_n   = 1'b1;
            resp_rdata_n = '0;
          end else begin
            state_n     = ACC0;
            mem_en_n    = 1'b1;
            mem_we_n    = c_store;
            mem_be_n    = lo_mask;
            mem_addr_n  = idx0;
            mem_wdata_n = c_store ? lo_data : '0;
          end
        end
      end
      ACC0: begin
`ifdef LSU_MISALIGNED_EN
        if (split) begin
          state_n     = ACC1;
          mem_en_n    = 1'b1;
          mem_we_n    = c_store;
          mem_be_n    = hi_mask;
          mem_addr_n  = idx1;
          mem_wdata_n = c_store ? hi_data : '0;
        end else
`endif
        if (c_store) begin
          state_n      = IDLE;
          resp_valid_n = 1'b1;
          resp_err_n   = 1'b0;
          resp_rdata_n = '0;
        end else begin
          state_n = FIN;
        end
      end
`ifdef LSU_MISALIGNED_EN
      ACC1: begin
        if (c_store) begin
          state_n      = IDLE;
          resp_valid_n = 1'b1;
          resp_err_n   = 1'b0;
          resp_rdata_n = '0;
        end else begin
          state_n = FIN;
        end
      end
`endif
      FIN: begin
        state_n      = IDLE;
        resp_valid_n = 1'b1;
        resp_err_n   = 1'b0;
        resp_rdata_n = load_value;
      end
      default: state_n = IDLE;
    endcase
  end

  // State, registered request fields and all registered outputs; reset abandons any access.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      r_store    <= 1'b0;
      r_unsigned <= 1'b0;
      r_size     <= 2'd0;
      r_addr     <= '0;
      r_wdata    <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_be     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      state      <= state_n;
      mem_en     <= mem_en_n;
      mem_we     <= mem_we_n;
      mem_be     <= mem_be_n;
      mem_addr   <= mem_addr_n;
      mem_wdata  <= mem_wdata_n;
      resp_valid <= resp_valid_n;
      resp_err   <= resp_err_n;
      resp_rdata <= resp_rdata_n;
      if (state == IDLE && req_valid) begin
        r_store    <= req_store;
        r_unsigned <= req_unsigned;
        r_size     <= req_size;
        r_addr     <= req_addr;
        r_wdata    <= req_wdata;
      end
    end
  end

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: self-checking bench for lsu with a 16-word synchronous memory model
// and a byte-level reference model of loads, stores, latency and errors.
// Follows LSU_MISALIGNED_EN the same way the design does.
module tb_lsu;
  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid, req_ready, req_store, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_en, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'h0;

  logic        poke_en = 1'b0;
  logic [3:0]  poke_idx = 4'd0;
  logic [31:0] poke_data = 32'h0;
  logic [31:0] dmem [16];
  logic [31:0] ref_mem [16];

  int checks = 0;
  int errors = 0;

  int          lat, n_acc;
  logic [31:0] acc_addr [2];
  logic [31:0] acc_wdata [2];
  logic [3:0]  acc_be [2];
  logic        acc_we [2];
  logic [31:0] got_rdata;
  logic        got_err, ready_acc, ready_resp, idle_dirty, seen;

  lsu #(.WORD_SIZE(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous data memory: byte-enabled writes, read data the cycle after the access.
  always @(posedge clk) begin
    if (poke_en) begin
      dmem[poke_idx] <= poke_data;
    end else if (mem_en && mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) dmem[mem_addr[3:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    if (mem_en && !mem_we) mem_rdata <= dmem[mem_addr[3:0]];
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_byte(input int a);
    logic [31:0] w;
    w = ref_mem[a / 4];
    return w[8*(a % 4) +: 8];
  endfunction

  function automatic logic [31:0] ref_load(input int a, input int n, input logic uns);
    logic [31:0] v;
    v = 32'h0;
    for (int k = 0; k < n; k++) v[8*k +: 8] = ref_byte(a + k);
    if (!uns && v[8*n-1])
      for (int k = n; k < 4; k++) v[8*k +: 8] = 8'hFF;
    return v;
  endfunction

  task automatic ref_store(input int a, input int n, input logic [31:0] wd);
    for (int k = 0; k < n; k++) ref_mem[(a + k) / 4][8*((a + k) % 4) +: 8] = wd[8*k +: 8];
  endtask

  task automatic poke(input int idx, input logic [31:0] d);
    poke_idx  = 4'(idx);
    poke_data = d;
    poke_en   = 1'b1;
    ref_mem[idx] = d;
    @(posedge clk);
    #1 poke_en = 1'b0;
    @(negedge clk);
  endtask

  // Issue one request and watch the bus until the response or a cycle budget runs out.
  task automatic apply_stimulus(input logic st, input logic [1:0] sz, input logic uns,
                                input logic [31:0] a, input logic [31:0] wd);
    req_store = st; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    ready_acc = req_ready;
    @(posedge clk);
    #1;
    req_valid    = 1'b0;
    req_store    = 1'($urandom);
    req_size     = 2'($urandom);
    req_unsigned = 1'($urandom);
    req_addr     = $urandom;
    req_wdata    = $urandom;
    lat = 0; n_acc = 0; idle_dirty = 1'b0; ready_resp = 1'b0;
    got_rdata = 32'h0; got_err = 1'b0;
    for (int k = 1; k <= 10 && lat == 0; k++) begin
      @(negedge clk);
      if (mem_en) begin
        if (n_acc < 2) begin
          acc_addr[n_acc] = mem_addr; acc_wdata[n_acc] = mem_wdata;
          acc_be[n_acc] = mem_be; acc_we[n_acc] = mem_we;
        end
        n_acc++;
      end else if (mem_we || mem_be != 4'h0 || mem_addr != 32'h0 || mem_wdata != 32'h0) begin
        idle_dirty = 1'b1;
      end
      if (resp_valid) begin
        lat = k; got_rdata = resp_rdata; got_err = resp_err; ready_resp = req_ready;
      end
    end
  endtask

  task automatic do_check(input logic st, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd, input string name);
    int n, ia, lat_exp, acc_exp;
    logic err_exp, split_exp;
    logic [31:0] rd_exp;
    ia = int'(a);
    n = 1 << sz;
    split_exp = ((ia % 4) + n) > 4;
    err_exp = (sz == 2'd3);
`ifndef LSU_MISALIGNED_EN
    if ((ia % n) != 0) err_exp = 1'b1;
`endif
    rd_exp  = (err_exp || st) ? 32'h0 : ref_load(ia, n, uns);
    lat_exp = err_exp ? 1 : (st ? (split_exp ? 3 : 2) : (split_exp ? 4 : 3));
    acc_exp = err_exp ? 0 : (split_exp ? 2 : 1);
    apply_stimulus(st, sz, uns, a, wd);
    check_output({name, ":ready_at_accept"}, 32'(ready_acc), 32'd1);
    check_output({name, ":latency"}, 32'(lat), 32'(lat_exp));
    check_output({name, ":resp_err"}, 32'(got_err), 32'(err_exp));
    check_output({name, ":resp_rdata"}, got_rdata, rd_exp);
    check_output({name, ":ready_at_resp"}, 32'(ready_resp), 32'd1);
    check_output({name, ":idle_bus_zero"}, 32'(idle_dirty), 32'd0);
    check_output({name, ":access_count"}, 32'(n_acc), 32'(acc_exp));
    if (!err_exp) begin
      check_output({name, ":index0"}, acc_addr[0], a >> 2);
      check_output({name, ":we0"}, 32'(acc_we[0]), 32'(st));
      if (st) ref_store(ia, n, wd);
    end
  endtask

  initial begin
    resetn = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (2) @(negedge clk);
    check_output("reset:ctrl", 32'({resp_valid, resp_err, mem_en, mem_we, mem_be}), 32'h0);
    check_output("reset:resp_rdata", resp_rdata, 32'h0);
    check_output("reset:mem_addr", mem_addr, 32'h0);
    check_output("reset:mem_wdata", mem_wdata, 32'h0);
    check_output("reset:req_ready", 32'(req_ready), 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    check_output("post_reset:req_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < 16; i++) poke(i, $urandom);

    poke(5, 32'h11223344);
    do_check(1'b0, 2'd2, 1'b0, 32'h14, 32'h0, "aligned_load");
    check_output("aligned_load:mem_addr", acc_addr[0], 32'd5);
    check_output("aligned_load:value", got_rdata, 32'h11223344);

    poke(0, 32'h0000_8080);
    do_check(1'b0, 2'd0, 1'b0, 32'h1, 32'h0, "lb_signed");
    check_output("lb_signed:value", got_rdata, 32'hFFFFFF80);
    do_check(1'b0, 2'd1, 1'b1, 32'h0, 32'h0, "lhu");
    check_output("lhu:value", got_rdata, 32'h00008080);

`ifdef LSU_MISALIGNED_EN
    poke(0, 32'hAABBCCDD);
    poke(1, 32'h11223344);
    do_check(1'b0, 2'd2, 1'b0, 32'h3, 32'h0, "split_load");
    check_output("split_load:value", got_rdata, 32'h223344AA);
    check_output("split_load:index1", acc_addr[1], 32'd1);
    do_check(1'b1, 2'd1, 1'b0, 32'h3, 32'h0000BEEF, "split_store");
    check_output("split_store:be0", 32'(acc_be[0]), 32'b1000);
    check_output("split_store:wdata0", acc_wdata[0], 32'hEF000000);
    check_output("split_store:be1", 32'(acc_be[1]), 32'b0001);
    check_output("split_store:index1", acc_addr[1], 32'd1);
    check_output("split_store:wdata1", acc_wdata[1], 32'h000000BE);
`else
    do_check(1'b0, 2'd2, 1'b0, 32'h2, 32'h0, "misaligned_word");
    check_output("misaligned_word:err", 32'(got_err), 32'd1);
    check_output("misaligned_word:no_access", 32'(n_acc), 32'd0);
`endif

    do_check(1'b0, 2'd3, 1'b0, 32'h8, 32'h0, "illegal_load");
    check_output("illegal_load:err", 32'(got_err), 32'd1);
    do_check(1'b1, 2'd3, 1'b0, 32'h8, 32'h12345678, "illegal_store");
    check_output("illegal_store:no_access", 32'(n_acc), 32'd0);

    // Reset in the middle of an aligned load.
    req_store = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h14;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check_output("midreset:mem_en_before", 32'(mem_en), 32'd1);
    resetn = 1'b0;
    @(negedge clk);
    check_output("midreset:ctrl", 32'({resp_valid, resp_err, mem_en, mem_we, mem_be}), 32'h0);
    check_output("midreset:resp_rdata", resp_rdata, 32'h0);
    check_output("midreset:mem_addr", mem_addr, 32'h0);
    check_output("midreset:mem_wdata", mem_wdata, 32'h0);
    check_output("midreset:req_ready", 32'(req_ready), 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    check_output("midreset:ready_after", 32'(req_ready), 32'd1);
    seen = resp_valid;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    check_output("midreset:no_response", 32'(seen), 32'd0);

    // Randomized back-to-back traffic against the byte-level model.
    for (int i = 0; i < 40; i++) begin
      logic [2:0] r;
      r = 3'($urandom);
      do_check(1'($urandom), (r == 3'd7) ? 2'd3 : 2'(r % 3), 1'($urandom),
               32'($urandom_range(0, 55)), $urandom, $sformatf("rand%0d", i));
    end

    for (int i = 0; i < 16; i++)
      check_output($sformatf("final_mem%0d", i), dmem[i], ref_mem[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
